modulo_carga_ff_t: RTL

Load controller that drives a bank of WIDTH T flip-flops to a requested parallel value. The bank only accepts toggle commands (t, enable), so this block converts a target value into the toggle vector (target XOR current state), issues it as a single enable strobe, and reads the bank back to confirm the result. It retries a bounded number of times and reports success or error with a one-cycle acknowledge. It sits between the control logic that requests register values and the flip-flop bank. It shares that bank's clock edge.

---
 rtl/modulo_carga_ff_t.sv | 125 ++++++++++++
 1 files changed

// File: rtl/modulo_carga_ff_t.sv
// Load controller for a bank of T flip-flops: turns a requested parallel value into
// a single toggle strobe, reads the bank back, retries a bounded number of times.
module modulo_carga_ff_t #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t,
  output logic             enable,
  output logic             busy,
  output logic             ack,
  output logic             err
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             enable_q, enable_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] diff_now;
  logic             bank_matches;
  logic             retry_left;

  assign diff_now     = tgt_q ^ q_fb;
  assign bank_matches = (q_fb == tgt_q);
  assign retry_left   = (retry_q < RETRY_LIMIT);

  // The bank toggles on the falling edge, so this block shares that edge.
  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      diff_q   <= '0;
      retry_q  <= '0;
      t_q      <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      diff_q   <= diff_d;
      retry_q  <= retry_d;
      t_q      <= t_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    diff_d  = diff_q;
    retry_d = retry_q;
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          tgt_d   = target;
          retry_d = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        diff_d  = diff_now;
        state_d = (diff_now == '0) ? S_DONE : S_APPLY;
      end
      S_APPLY: state_d = S_WAIT;
      S_WAIT:  state_d = S_CHECK;
      S_CHECK: begin
        if (bank_matches) begin
          state_d = S_DONE;
        end else if (retry_left) begin
          retry_d = retry_q + RW'(1);
          state_d = S_CALC;
        end else begin
          state_d = S_ERROR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with its state.
  always_comb begin
    enable_d = (state_d == S_APPLY);
    t_d      = enable_d ? diff_d : '0;
    busy_d   = (state_d != S_IDLE);
    ack_d    = (state_d == S_DONE) || (state_d == S_ERROR);
    err_d    = (state_d == S_ERROR);
  end

  assign t      = t_q;
  assign enable = enable_q;
  assign busy   = busy_q;
  assign ack    = ack_q;
  assign err    = err_q;

endmodule
